weight_fetch_seq: RTL and testbench
===================================

// Module: weight_fetch_seq
// PURPOSE
//  Reader for the synchronous 8-bit signed weight ROM (registered read, 1-cycle latency).
//  On start, issues N sequential ROM addresses from base_addr, absorbs read latency, and
//  streams weights to the L1 MAC datapath over valid/ready with backpressure.
//  Sits between the weight ROM and the trigger MAC array; one layer load per start.
// PARAMETERS
//  DEPTH   9  number of ROM entries; valid addresses are 0..DEPTH-1
//  ADDR_W  8  ROM address width
//  DATA_W  8  signed weight width
// PORTS
//  clk          in   1          single clock, all logic on posedge
//  rst          in   1          synchronous, active-high reset
//  start        in   1          1-cycle pulse; accepted only in IDLE
//  base_addr    in   ADDR_W     first ROM address, sampled on accepted start
//  num_weights  in   ADDR_W     beat count, sampled on accepted start
//  busy         out  1          high from accepted start until done
//  done         out  1          1-cycle pulse after last beat handshake (or empty job)
//  cfg_err      out  1          1-cycle pulse when start rejected (base_addr >= DEPTH)
//  rom_addr     out  ADDR_W     ROM address (registered)
//  rom_data     in   DATA_W     ROM data, valid 1 cycle after rom_addr issued
//  w_data       out  DATA_W     signed weight beat
//  w_valid      out  1          beat valid
//  w_ready      in   1          consumer ready; transfer when w_valid & w_ready
//  w_last       out  1          high with final beat of job
// BEHAVIOUR
//  Reset: busy/done/cfg_err/w_valid/w_last=0, rom_addr=0, w_data=0, FSM=IDLE, FIFO empty,
//   issue/beat counters=0, in-flight flag cleared; reset mid-job aborts, pending data dropped.
//  FSM: IDLE -> FETCH on start with base_addr<DEPTH and num_weights>0;
//   IDLE -> DONE on start with num_weights==0 (no beats, done next cycle);
//   IDLE stays on start with base_addr>=DEPTH, cfg_err pulses next cycle;
//   FETCH -> DRAIN when all N addresses issued; DRAIN -> DONE on last beat handshake;
//   DONE -> IDLE unconditionally (done=1 for that one cycle). start outside IDLE ignored.
//  Address: beat i reads (base_addr+i) mod DEPTH; wrap from DEPTH-1 to 0, never >= DEPTH.
//  Read pipe: issue registers rom_addr; in-flight flag set; next cycle rom_data pushed to FIFO.
//  Buffering: 2-entry FIFO feeds w_*. Issue allowed when fifo_count+inflight-pop < 2, so
//   no read is ever issued without guaranteed space; with w_ready=1 throughput is 1 beat/clk,
//   first w_valid 2 cycles after accepted start.
//  w_data/w_valid held stable while w_valid & !w_ready. Push and pop in same cycle legal.
//  w_last asserted with beat N-1 (beat counter == num_weights-1), never otherwise.
// CONFIGURATION
//  WFETCH_CHECKSUM_EN defined: extra port checksum out 16 signed; cleared on accepted start,
//   adds sign-extended w_data on every handshake, stable from done until next accepted start;
//   reset value 0.
//  Undefined: no checksum port, no accumulator logic.
// STRUCTURE
//  Package wfetch_pkg: FSM state enum (IDLE, FETCH, DRAIN, DONE), DEPTH/ADDR_W/DATA_W
//   defaults, CHECKSUM_W=16.
//  Sub-module wfetch_skid_fifo: 2-entry sync FIFO, push/pop/count, sync active-high rst.
// TESTING
//  ROM 0..8 = 01,FF,02,FE,03,FD,04,FC,05; start base=0 N=9, w_ready=1 -> beats 1,-1,2,-2,3,-3,
//   4,-4,5 back-to-back, w_last on 9th, done 1 cycle later; checksum=5 when enabled.
//  base=7 N=4 -> rom_addr 7,8,0,1; beats FC,05,01,FF.
//  w_ready toggling 1,0,0,1 random -> no beat lost/duplicated, w_data stable while stalled.
//  start N=0 -> no w_valid, done pulse next cycle; start base=9 -> cfg_err pulse, busy stays 0.
//  start during FETCH -> ignored, job unchanged; rst mid-job -> all outputs 0 next cycle,
//   fresh start runs a clean job.

Source files
------------

// File: rtl/wfetch_pkg.sv
// rtl/wfetch_pkg.sv - shared constants, FSM state type and address wrap helper for the weight fetch sequencer
package wfetch_pkg;
    localparam int DEPTH      = 9;
    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 8;
    localparam int CHECKSUM_W = 16;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    // Sequential ROM address with wrap from the last entry back to 0.
    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(DEPTH - 1)) ? '0 : a + ADDR_W'(1);
    endfunction
endpackage

// File: rtl/wfetch_skid_fifo.sv
// rtl/wfetch_skid_fifo.sv - 2-entry synchronous FIFO buffering ROM read data ahead of the weight stream
module wfetch_skid_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       count
);
    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Head entry is only overwritten when the FIFO is empty, so a stalled beat stays stable.
    assign dout = mem[rd_ptr];
endmodule

// File: rtl/weight_fetch_seq.sv
// rtl/weight_fetch_seq.sv - weight ROM reader streaming N weights per start; optional checksum port under WFETCH_CHECKSUM_EN
module weight_fetch_seq
    import wfetch_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [ADDR_W-1:0]            base_addr,
    input  logic [ADDR_W-1:0]            num_weights,
    output logic                         busy,
    output logic                         done,
    output logic                         cfg_err,
    output logic [ADDR_W-1:0]            rom_addr,
    input  logic [DATA_W-1:0]            rom_data,
    output logic [DATA_W-1:0]            w_data,
    output logic                         w_valid,
    input  logic                         w_ready,
`ifdef WFETCH_CHECKSUM_EN
    output logic signed [CHECKSUM_W-1:0] checksum,
`endif
    output logic                         w_last
);
    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] n_reg;
    logic [ADDR_W-1:0] issue_cnt;
    logic [ADDR_W-1:0] beat_cnt;
    logic              inflight;
    logic [1:0]        fifo_count;
    logic              pop;
    logic              issue;
    logic              start_ok;
    logic              start_bad;
    logic              last_issue;
    logic              last_beat;

    assign w_valid    = (fifo_count != 2'd0);
    assign pop        = w_valid & w_ready;
    assign start_ok   = (state == IDLE) && start && (base_addr < ADDR_W'(DEPTH));
    assign start_bad  = (state == IDLE) && start && !(base_addr < ADDR_W'(DEPTH));
    // Only issue when the read is guaranteed a FIFO slot on arrival.
    assign issue      = (state == FETCH) &&
                        (({1'b0, fifo_count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));
    assign last_issue = (issue_cnt == n_reg - ADDR_W'(1));
    assign last_beat  = (beat_cnt == n_reg - ADDR_W'(1));
    assign w_last     = w_valid && last_beat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nxt = (num_weights == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (issue && last_issue) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && last_beat) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            FETCH, DRAIN: busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr  <= '0;
            next_addr <= '0;
            n_reg     <= '0;
            issue_cnt <= '0;
            beat_cnt  <= '0;
            inflight  <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err  <= start_bad;
            inflight <= issue;
            if (start_ok) begin
                next_addr <= base_addr;
                n_reg     <= num_weights;
                issue_cnt <= '0;
                beat_cnt  <= '0;
            end else begin
                if (issue) begin
                    rom_addr  <= next_addr;
                    next_addr <= wrap_inc(next_addr);
                    issue_cnt <= issue_cnt + ADDR_W'(1);
                end
                if (pop) begin
                    beat_cnt <= beat_cnt + ADDR_W'(1);
                end
            end
        end
    end

    wfetch_skid_fifo #(
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .pop   (pop),
        .din   (rom_data),
        .dout  (w_data),
        .count (fifo_count)
    );

`ifdef WFETCH_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum <= '0;
        end else if (start_ok) begin
            checksum <= '0;
        end else if (pop) begin
            checksum <= checksum + {{(CHECKSUM_W-DATA_W){w_data[DATA_W-1]}}, w_data};
        end
    end
`endif
endmodule

// File: tb/tb_weight_fetch_seq.sv
// tb/tb_weight_fetch_seq.sv - directed self-checking bench for weight_fetch_seq
module tb_weight_fetch_seq;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] base_addr;
    logic [7:0] num_weights;
    logic       busy;
    logic       done;
    logic       cfg_err;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] w_data;
    logic       w_valid;
    logic       w_ready;
    logic       w_last;
`ifdef WFETCH_CHECKSUM_EN
    logic signed [15:0] checksum;
`endif

    logic [7:0] rom_mem [0:8];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign rom_data = (rom_addr < 8'd9) ? rom_mem[rom_addr[3:0]] : 8'h00;

    weight_fetch_seq dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .num_weights (num_weights),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .w_data      (w_data),
        .w_valid     (w_valid),
        .w_ready     (w_ready),
`ifdef WFETCH_CHECKSUM_EN
        .checksum    (checksum),
`endif
        .w_last      (w_last)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic [7:0] b, input logic [7:0] n);
        start       = 1'b1;
        base_addr   = b;
        num_weights = n;
        tick();
        start = 1'b0;
    endtask

    // Consume n beats, checking order, w_last placement and stability under stall.
    task automatic run_beats(input string tag, input int base, input int n, input bit stall_mode);
        int got = 0;
        int cyc = 0;
        int gaps = 0;
        int pat = 0;
        bit seen = 0;
        bit held = 0;
        logic [7:0] hold = 8'h00;
        while (got < n && cyc < 400) begin
            if (!stall_mode)  w_ready = 1'b1;
            else if (pat < 4) w_ready = (pat == 0 || pat == 3);
            else              w_ready = 1'($urandom_range(0, 1));
            if (w_valid) begin
                pat++;
                seen = 1;
                if (held) chk({tag, " stall_hold"}, w_data, hold);
                if (w_ready) begin
                    chk({tag, " beat"}, w_data, rom_mem[(base + got) % 9]);
                    chk({tag, " last"}, w_last, (got == n - 1));
                    got++;
                    held = 0;
                end else begin
                    hold = w_data;
                    held = 1;
                end
            end else if (seen) begin
                gaps++;
            end
            tick();
            cyc++;
        end
        chk({tag, " beat_count"}, got, n);
        if (!stall_mode) chk({tag, " gaps"}, gaps, 0);
        chk({tag, " done"}, done, 1'b1);
        chk({tag, " valid_after"}, w_valid, 1'b0);
        tick();
        chk({tag, " done_clear"}, done, 1'b0);
        chk({tag, " idle_busy"}, busy, 1'b0);
    endtask

    initial begin
        rom_mem[0] = 8'h01; rom_mem[1] = 8'hFF; rom_mem[2] = 8'h02;
        rom_mem[3] = 8'hFE; rom_mem[4] = 8'h03; rom_mem[5] = 8'hFD;
        rom_mem[6] = 8'h04; rom_mem[7] = 8'hFC; rom_mem[8] = 8'h05;
        rst = 1'b1; start = 1'b0; base_addr = '0; num_weights = '0; w_ready = 1'b1;
        tick();
        tick();
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst cfg_err", cfg_err, 1'b0);
        chk("rst w_valid", w_valid, 1'b0);
        chk("rst w_last", w_last, 1'b0);
        chk("rst rom_addr", rom_addr, 8'h00);
        chk("rst w_data", w_data, 8'h00);
        rst = 1'b0;
        tick();

        // Full ROM, back-to-back.
        do_start(8'd0, 8'd9);
        chk("t1 busy", busy, 1'b1);
        chk("t1 valid_c0", w_valid, 1'b0);
        tick();
        chk("t1 valid_c1", w_valid, 1'b0);
        chk("t1 rom_addr0", rom_addr, 8'h00);
        tick();
        chk("t1 valid_c2", w_valid, 1'b1);
        run_beats("t1", 0, 9, 1'b0);
`ifdef WFETCH_CHECKSUM_EN
        chk("t1 checksum", checksum, 16'd5);
`endif

        // Wrap-around addressing.
        do_start(8'd7, 8'd4);
        tick();
        chk("t2 addr7", rom_addr, 8'd7);
        tick();
        chk("t2 addr8", rom_addr, 8'd8);
        chk("t2 beat0", w_data, 8'hFC);
        chk("t2 last0", w_last, 1'b0);
        tick();
        chk("t2 addr0", rom_addr, 8'd0);
        chk("t2 beat1", w_data, 8'h05);
        tick();
        chk("t2 addr1", rom_addr, 8'd1);
        chk("t2 beat2", w_data, 8'h01);
        tick();
        chk("t2 beat3", w_data, 8'hFF);
        chk("t2 last3", w_last, 1'b1);
        chk("t2 addr_hold", rom_addr, 8'd1);
        tick();
        chk("t2 done", done, 1'b1);
        chk("t2 valid_after", w_valid, 1'b0);
        tick();
        chk("t2 done_clear", done, 1'b0);

        // Backpressure.
        do_start(8'd2, 8'd6);
        run_beats("t3", 2, 6, 1'b1);
        w_ready = 1'b1;

        // Empty job.
        do_start(8'd0, 8'd0);
        chk("t4 done", done, 1'b1);
        chk("t4 valid", w_valid, 1'b0);
        tick();
        chk("t4 done_clear", done, 1'b0);
        chk("t4 valid2", w_valid, 1'b0);

        // Out-of-range base.
        do_start(8'd9, 8'd3);
        chk("t5 cfg_err", cfg_err, 1'b1);
        chk("t5 busy", busy, 1'b0);
        tick();
        chk("t5 cfg_err_clear", cfg_err, 1'b0);
        chk("t5 busy2", busy, 1'b0);
        chk("t5 valid", w_valid, 1'b0);

        // Start while busy is ignored.
        do_start(8'd0, 8'd3);
        do_start(8'd5, 8'd2);
        chk("t6 busy", busy, 1'b1);
        chk("t6 cfg_err", cfg_err, 1'b0);
        run_beats("t6", 0, 3, 1'b0);

        // Reset mid-job, then a clean job.
        do_start(8'd3, 8'd5);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("t7 busy", busy, 1'b0);
        chk("t7 valid", w_valid, 1'b0);
        chk("t7 last", w_last, 1'b0);
        chk("t7 done", done, 1'b0);
        chk("t7 rom_addr", rom_addr, 8'h00);
        chk("t7 w_data", w_data, 8'h00);
`ifdef WFETCH_CHECKSUM_EN
        chk("t7 checksum", checksum, 16'd0);
`endif
        rst = 1'b0;
        tick();
        do_start(8'd4, 8'd3);
        run_beats("t7", 4, 3, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
